// File: rtl/sisc_ctrl_mc_if.sv
// sisc_ctrl_mc_if
//   Bundle between the SISC multicycle controller and its datapath / memory.
//   Datapath -> controller: opcode, mm, stat, mem_ack.
//   Controller -> datapath: rf_we, alu_op, wb_sel, br_sel, rb_sel, wr_sel, mm_sel,
//                           ir_load, pc_sel, pc_write, pc_rst, dm_we, mem_req.
//   Modports: master = controller side, slave = datapath side.
interface sisc_ctrl_mc_if #(
    parameter int unsigned OP_W = 4,
    parameter int unsigned CC_W = 4
);
    logic [OP_W-1:0] opcode;
    logic [CC_W-1:0] mm;
    logic [CC_W-1:0] stat;
    logic            mem_ack;

    logic            rf_we;
    logic [1:0]      alu_op;
    logic [1:0]      wb_sel;
    logic            br_sel;
    logic            rb_sel;
    logic            wr_sel;
    logic [1:0]      mm_sel;
    logic            ir_load;
    logic            pc_sel;
    logic            pc_write;
    logic            pc_rst;
    logic            dm_we;
    logic            mem_req;

    modport master (
        input  opcode, mm, stat, mem_ack,
        output rf_we, alu_op, wb_sel, br_sel, rb_sel, wr_sel, mm_sel,
               ir_load, pc_sel, pc_write, pc_rst, dm_we, mem_req
    );

    modport slave (
        output opcode, mm, stat, mem_ack,
        input  rf_we, alu_op, wb_sel, br_sel, rb_sel, wr_sel, mm_sel,
               ir_load, pc_sel, pc_write, pc_rst, dm_we, mem_req
    );
endinterface

// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc
//   Multicycle control FSM for the SISC datapath with request/acknowledge memory
//   handshakes, instruction-dependent state skipping, an ack watchdog and a HALT state.
//   Ports:
//     clk    - clock, rising edge
//     rst_f  - asynchronous active-low reset
//     bus    - sisc_ctrl_mc_if.master: decode inputs, mem_ack, datapath controls, mem_req
//     halted - registered, 1 while in HALT
//     fault  - registered sticky flag: illegal opcode or ack timeout
//     state  - current state, for debug
module sisc_ctrl_mc #(
    parameter int unsigned OP_W        = 4,
    parameter int unsigned CC_W        = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_f,
    sisc_ctrl_mc_if.master        bus,
    output logic                  halted,
    output logic                  fault,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        StStart     = 4'd0,
        StFetch     = 4'd1,
        StDecode    = 4'd2,
        StExecute   = 4'd3,
        StMem       = 4'd4,
        StWriteback = 4'd5,
        StHalt      = 4'd6
    } state_e;

    localparam logic [3:0] OpNoop = 4'd0;
    localparam logic [3:0] OpLod  = 4'd1;
    localparam logic [3:0] OpStr  = 4'd2;
    localparam logic [3:0] OpSwp  = 4'd3;
    localparam logic [3:0] OpBra  = 4'd4;
    localparam logic [3:0] OpBrr  = 4'd5;
    localparam logic [3:0] OpBne  = 4'd6;
    localparam logic [3:0] OpBnr  = 4'd7;
    localparam logic [3:0] OpAlu  = 4'd8;
    localparam logic [3:0] OpHlt  = 4'd15;

    localparam logic [CC_W-1:0] MmZero = '0;
    localparam logic [CC_W-1:0] Mm0001 = CC_W'(1);
    localparam logic [CC_W-1:0] Mm1000 = CC_W'(8);
    localparam logic [CC_W-1:0] Mm1001 = CC_W'(9);
    localparam logic [7:0]      WaitLast = 8'(ACK_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       halted_q, fault_q, fault_set;

    logic       rf_we, br_sel, rb_sel, wr_sel, ir_load, pc_sel, pc_write, pc_rst, dm_we;
    logic       mem_req;
    logic [1:0] alu_op, wb_sel, mm_sel;

    logic [3:0] op;
    logic       legal, is_branch, taken, hit, post_mod, is_ldst;
    logic [1:0] addr_sel;

    // Opcode classification and condition evaluation, independent of state.
    always_comb begin
        op        = bus.opcode[3:0];
        hit       = |(bus.mm & bus.stat);
        is_branch = (op == OpBra) || (op == OpBrr) || (op == OpBne) || (op == OpBnr);
        is_ldst   = (op == OpLod) || (op == OpStr);
        legal     = ((bus.opcode >> 4) == OP_W'(0)) &&
                    (op <= OpAlu || op == OpHlt);
        taken     = ((op == OpBra) || (op == OpBrr)) ? hit : !hit;
        post_mod  = (bus.mm == Mm1001) || (bus.mm == Mm0001);
        // Data address source; held unchanged from EXECUTE through MEM.
        if (bus.mm == MmZero) begin
            addr_sel = 2'b01;
        end else if (bus.mm == Mm1000 || bus.mm == Mm1001) begin
            addr_sel = 2'b00;
        end else begin
            addr_sel = 2'b10;
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        alu_op    = 2'b10;
        wb_sel    = 2'b00;
        br_sel    = 1'b0;
        rb_sel    = 1'b0;
        wr_sel    = 1'b0;
        mm_sel    = 2'b01;
        ir_load   = 1'b0;
        pc_sel    = 1'b0;
        pc_write  = 1'b0;
        pc_rst    = 1'b0;
        dm_we     = 1'b0;
        mem_req   = 1'b0;
        fault_set = 1'b0;
        state_d   = state_q;

        case (state_q)
            StStart: begin
                pc_rst  = 1'b1;
                state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                rb_sel = legal && ((op == OpStr) || (op == OpSwp));
                br_sel = legal && ((op == OpBra) || (op == OpBne));
                if (!legal) begin
                    fault_set = 1'b1;
                    state_d   = StHalt;
                end else if (op == OpHlt) begin
                    state_d = StHalt;
                end else if (is_branch || op == OpNoop) begin
                    if (is_branch && taken) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                    state_d = StFetch;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                if (op == OpAlu) begin
                    alu_op  = (bus.mm == Mm1000) ? 2'b01 : 2'b00;
                    state_d = StWriteback;
                end else begin
                    if (is_ldst) begin
                        alu_op = 2'b01;
                        mm_sel = addr_sel;
                    end
                    state_d = StMem;
                end
            end
            StMem: begin
                if (op == OpSwp) begin
                    wr_sel  = 1'b1;
                    wb_sel  = 2'b11;
                    rf_we   = 1'b1;
                    state_d = StWriteback;
                end else begin
                    mem_req = 1'b1;
                    mm_sel  = addr_sel;
                    dm_we   = (op == OpStr);
                    if (op == OpLod) begin
                        wb_sel = 2'b01;
                        rf_we  = bus.mem_ack;
                    end
                    if (bus.mem_ack) begin
                        state_d = post_mod ? StWriteback : StFetch;
                    end
                end
            end
            StWriteback: begin
                if (op == OpAlu) begin
                    rf_we = 1'b1;
                end else if (op == OpSwp) begin
                    wb_sel = 2'b10;
                    rf_we  = 1'b1;
                end else begin
                    wr_sel = 1'b1;
                    alu_op = 2'b01;
                    rf_we  = 1'b1;
                end
                state_d = StFetch;
            end
            StHalt: ;
            default: state_d = StStart;
        endcase

        // Watchdog: this is the ACK_TIMEOUT-th unacknowledged request cycle.
        if (mem_req && !bus.mem_ack && wait_q == WaitLast) begin
            fault_set = 1'b1;
            state_d   = StHalt;
        end

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (mem_req && !bus.mem_ack) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q  <= StStart;
            wait_q   <= 8'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= (state_d == StHalt);
            fault_q  <= fault_q | fault_set;
        end
    end

    assign bus.rf_we    = rf_we;
    assign bus.alu_op   = alu_op;
    assign bus.wb_sel   = wb_sel;
    assign bus.br_sel   = br_sel;
    assign bus.rb_sel   = rb_sel;
    assign bus.wr_sel   = wr_sel;
    assign bus.mm_sel   = mm_sel;
    assign bus.ir_load  = ir_load;
    assign bus.pc_sel   = pc_sel;
    assign bus.pc_write = pc_write;
    assign bus.pc_rst   = pc_rst;
    assign bus.dm_we    = dm_we;
    assign bus.mem_req  = mem_req;

    assign halted = halted_q;
    assign fault  = fault_q;
    assign state  = state_q;
endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb_sisc_ctrl_mc
//   Directed self-checking bench for sisc_ctrl_mc: reset, ADD, post-modify LOD with
//   wait states, branch conditions, HLT, illegal opcode, fetch timeout, reset mid-STR.
module tb_sisc_ctrl_mc;
    logic       clk = 1'b0;
    logic       rst_f = 1'b0;
    logic       halted, fault;
    logic [3:0] state;
    int         checks = 0;
    int         errors = 0;

    sisc_ctrl_mc_if #(.OP_W(4), .CC_W(4)) bus ();

    sisc_ctrl_mc #(.OP_W(4), .CC_W(4), .ACK_TIMEOUT(15)) dut (
        .clk    (clk),
        .rst_f  (rst_f),
        .bus    (bus),
        .halted (halted),
        .fault  (fault),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                         input logic ack);
        bus.opcode  = op;
        bus.mm      = m;
        bus.stat    = s;
        bus.mem_ack = ack;
        #1;
    endtask

    // Assert reset, confirm fault clears, release after a falling edge.
    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        drive(4'd0, 4'd0, 4'd0, 1'b0);
        rst_f = 1'b0;
        #1;
        check("reset_state",   32'(state),       32'd0);
        check("reset_pc_rst",  32'(bus.pc_rst),  32'd1);
        check("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check("reset_alu_op",  32'(bus.alu_op),  32'd2);
        check("reset_mm_sel",  32'(bus.mm_sel),  32'd1);
        check("reset_halted",  32'(halted),      32'd0);
        check("reset_fault",   32'(fault),       32'd0);

        // ADD, zero-wait memory: 1,2,3,5,1
        drive(4'd8, 4'd0, 4'd0, 1'b1);
        do_reset();
        tick();
        check("add_s1",      32'(state),       32'd1);
        check("add_ir_load", 32'(bus.ir_load), 32'd1);
        check("add_rf_we1",  32'(bus.rf_we),   32'd0);
        tick();
        check("add_s2",      32'(state),       32'd2);
        check("add_rf_we2",  32'(bus.rf_we),   32'd0);
        tick();
        check("add_s3",      32'(state),       32'd3);
        check("add_alu_op",  32'(bus.alu_op),  32'd0);
        check("add_rf_we3",  32'(bus.rf_we),   32'd0);
        tick();
        check("add_s5",      32'(state),       32'd5);
        check("add_rf_we5",  32'(bus.rf_we),   32'd1);
        tick();
        check("add_s1b",     32'(state),       32'd1);

        // LOD, mm=1001 (post-modify), 3 wait cycles in MEM
        drive(4'd1, 4'd9, 4'd0, 1'b1);
        tick();
        check("lod_s2",      32'(state),      32'd2);
        tick();
        check("lod_s3",      32'(state),      32'd3);
        check("lod_alu_op",  32'(bus.alu_op), 32'd1);
        check("lod_mm_sel3", 32'(bus.mm_sel), 32'd0);
        drive(4'd1, 4'd9, 4'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lod_wait_state", 32'(state),       32'd4);
            check("lod_wait_req",   32'(bus.mem_req), 32'd1);
            check("lod_wait_rf_we", 32'(bus.rf_we),   32'd0);
            check("lod_wait_mmsel", 32'(bus.mm_sel),  32'd0);
            tick();
        end
        drive(4'd1, 4'd9, 4'd0, 1'b1);
        check("lod_ack_state",  32'(state),       32'd4);
        check("lod_ack_req",    32'(bus.mem_req), 32'd1);
        check("lod_ack_rf_we",  32'(bus.rf_we),   32'd1);
        check("lod_ack_wb_sel", 32'(bus.wb_sel),  32'd1);
        tick();
        check("lod_wb_state",  32'(state),      32'd5);
        check("lod_wb_wr_sel", 32'(bus.wr_sel), 32'd1);
        check("lod_wb_wb_sel", 32'(bus.wb_sel), 32'd0);
        check("lod_wb_alu_op", 32'(bus.alu_op), 32'd1);
        check("lod_wb_rf_we",  32'(bus.rf_we),  32'd1);
        tick();
        check("lod_back_fetch", 32'(state), 32'd1);

        // BRA mm=0010 stat=0010: taken, absolute
        drive(4'd4, 4'd2, 4'd2, 1'b1);
        tick();
        check("bra_s2",       32'(state),        32'd2);
        check("bra_pc_sel",   32'(bus.pc_sel),   32'd1);
        check("bra_pc_write", 32'(bus.pc_write), 32'd1);
        check("bra_br_sel",   32'(bus.br_sel),   32'd1);
        tick();
        check("bra_fetch",    32'(state),        32'd1);

        // BNE mm=0000: unconditionally taken
        drive(4'd6, 4'd0, 4'hf, 1'b1);
        tick();
        check("bne_pc_sel",   32'(bus.pc_sel),   32'd1);
        check("bne_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        check("bne_fetch",    32'(state),        32'd1);

        // BRR mm=0100 stat=0011: not taken
        drive(4'd5, 4'd4, 4'd3, 1'b1);
        tick();
        check("brr_s2",       32'(state),        32'd2);
        check("brr_pc_sel",   32'(bus.pc_sel),   32'd0);
        check("brr_pc_write", 32'(bus.pc_write), 32'd0);
        tick();
        check("brr_fetch",    32'(state),        32'd1);

        // HLT: HALT without fault
        drive(4'd15, 4'd0, 4'd0, 1'b1);
        tick();
        tick();
        check("hlt_state",   32'(state),       32'd6);
        check("hlt_halted",  32'(halted),      32'd1);
        check("hlt_fault",   32'(fault),       32'd0);
        check("hlt_mem_req", 32'(bus.mem_req), 32'd0);

        // Illegal opcode 9: HALT with fault
        drive(4'd9, 4'd0, 4'd0, 1'b1);
        do_reset();
        tick();
        tick();
        tick();
        check("ill_state",  32'(state),  32'd6);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_fault",  32'(fault),  32'd1);

        // Fetch timeout: 15 unacknowledged cycles, then HALT for good
        drive(4'd0, 4'd0, 4'd0, 1'b0);
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) begin
            check("to_wait_fetch", 32'(state), 32'd1);
            tick();
        end
        check("to_state",  32'(state),  32'd6);
        check("to_halted", 32'(halted), 32'd1);
        check("to_fault",  32'(fault),  32'd1);
        drive(4'd8, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("to_stay_halt", 32'(state), 32'd6);
        end
        check("to_halt_req",    32'(bus.mem_req), 32'd0);
        check("to_halt_alu_op", 32'(bus.alu_op),  32'd2);
        check("to_halt_mm_sel", 32'(bus.mm_sel),  32'd1);

        // STR mm=0000, reset dropped mid-MEM
        drive(4'd2, 4'd0, 4'd0, 1'b1);
        do_reset();
        tick();
        tick();
        check("str_rb_sel", 32'(bus.rb_sel), 32'd1);
        tick();
        check("str_alu_op", 32'(bus.alu_op), 32'd1);
        check("str_mm_sel", 32'(bus.mm_sel), 32'd1);
        drive(4'd2, 4'd0, 4'd0, 1'b0);
        tick();
        check("str_mem_state", 32'(state),       32'd4);
        check("str_dm_we",     32'(bus.dm_we),   32'd1);
        check("str_mem_req",   32'(bus.mem_req), 32'd1);
        #1;
        rst_f = 1'b0;
        #1;
        check("str_rst_dm_we",   32'(bus.dm_we),   32'd0);
        check("str_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("str_rst_state",   32'(state),       32'd0);
        check("str_rst_pc_rst",  32'(bus.pc_rst),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
